rom_stream_reader: RTL

Address generator and output buffer that sits directly upstream of the 8K x 8 synchronous ROM (registered read, 1-cycle latency). On a start command it sweeps a contiguous address range and issues one read per cycle. It captures the returned bytes into a small FIFO and presents them as a valid/ready byte stream to downstream logic. Read issue is credit-limited, so backpressure never loses or duplicates a byte.

---
 rtl/rom_stream_reader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rom_stream_reader.sv
// Sweeps a contiguous ROM address range, buffers the 1-cycle-latency read data
// in a small FIFO and presents it as a valid/ready byte stream.
// Build macro ROM_STREAM_CHKSUM_EN adds a running modulo-2**DATA_W byte checksum output.
module rom_stream_reader #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 14,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef ROM_STREAM_CHKSUM_EN
  ,
  output logic [DATA_W-1:0] chksum
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  remaining;
  logic              inflight;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic [CW:0]       used;
  logic [CW:0]       limit;
  logic              push;
  logic              pop;
  logic              issue;

  // Stream: a byte moves on every cycle where out_valid & out_ready; once
  // out_valid is high it stays high with out_data stable until that transfer.
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign busy      = (state != S_IDLE);
  assign pop       = out_valid & out_ready;
  assign push      = inflight;

  // A read is only issued if a FIFO slot is guaranteed when its data returns.
  assign used  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign limit = {1'b0, DEPTH_C} + {{CW{1'b0}}, pop};
  assign issue = (state == S_FETCH) && (remaining != '0) && (used < limit);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (!push && pop) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rom_addr  <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
`ifdef ROM_STREAM_CHKSUM_EN
      chksum    <= '0;
`endif
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      count    <= count_next;
      if (issue) begin
        rom_addr  <= rom_addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
      if (push) begin
        mem[wr_ptr] <= rom_q;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
`ifdef ROM_STREAM_CHKSUM_EN
        chksum <= chksum + out_data;
`endif
      end
      case (state)
        S_IDLE: begin
          if (start) begin
`ifdef ROM_STREAM_CHKSUM_EN
            chksum <= '0;
`endif
            if (length != '0) begin
              rom_addr  <= start_addr;
              remaining <= length;
              state     <= S_FETCH;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (issue && remaining == LEN_W'(1)) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Finish on the handshake of the last byte so done lands the cycle after.
          if (!inflight && count_next == '0) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
